// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the WB/MC write-side, decode read-address and regfile write signals of regfile_wb_arbiter.
// The master side is the pipeline/MC environment; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) ();
  logic          wb_we;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          mc_valid;
  logic          mc_ready;
  logic [AW-1:0] mc_waddr;
  logic [DW-1:0] mc_wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          rd_hazard1;
  logic          rd_hazard2;
  logic          stall_req;
  logic          waw_err;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  modport master (
    output wb_we, wb_waddr, wb_wdata, mc_valid, mc_waddr, mc_wdata, raddr1, raddr2,
    input  mc_ready, rd_hazard1, rd_hazard2, stall_req, waw_err, we, waddr, wdata
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, mc_valid, mc_waddr, mc_wdata, raddr1, raddr2,
    output mc_ready, rd_hazard1, rd_hazard2, stall_req, waw_err, we, waddr, wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: WB always wins, MC results queue in a small FIFO and drain on idle WB cycles.
// Optional WB_ARB_STATS_EN adds stat_stall_cyc / stat_mc_wr counters.
module regfile_wb_arbiter #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  regfile_wb_arbiter_if.slave       bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]               stat_stall_cyc,
  output logic [31:0]               stat_mc_wr
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_WB,
    GNT_MC
  } gnt_e;

  logic [AW-1:0]         r_mem_addr [FIFO_DEPTH];
  logic [DW-1:0]         r_mem_data [FIFO_DEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [WW-1:0]         r_wait_cnt;
  logic                  r_we;
  logic [AW-1:0]         r_waddr;
  logic [DW-1:0]         r_wdata;
  logic                  r_stall_req;
  logic                  r_waw_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_mc_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wb_req;
  gnt_e                  w_gnt;
  logic [FIFO_DEPTH-1:0] w_slot_vld;
  logic                  w_hit1;
  logic                  w_hit2;
  logic                  w_hit_wb;
  logic [WW-1:0]         w_wait_nxt;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_mc_ready = !rst && !w_full;
  assign w_wb_req   = bus.wb_we && (bus.wb_waddr != '0);
  // Writes to r0 are accepted from MC but never stored.
  assign w_push     = bus.mc_valid && w_mc_ready && (bus.mc_waddr != '0);

  always_comb begin
    w_gnt = GNT_IDLE;
    if (w_wb_req)      w_gnt = GNT_WB;
    else if (!w_empty) w_gnt = GNT_MC;
  end

  assign w_pop = (w_gnt == GNT_MC);

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_slot_vld = '0;
    for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
      w_slot_vld[j] = ({1'b0, PW'(PW'(j) - r_rd_ptr)} < r_count);
    end
  end

  always_comb begin
    w_hit1   = 1'b0;
    w_hit2   = 1'b0;
    w_hit_wb = 1'b0;
    for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
      if (w_slot_vld[j]) begin
        if (r_mem_addr[j] == bus.raddr1)   w_hit1   = 1'b1;
        if (r_mem_addr[j] == bus.raddr2)   w_hit2   = 1'b1;
        if (r_mem_addr[j] == bus.wb_waddr) w_hit_wb = 1'b1;
      end
    end
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (w_pop || w_empty)                w_wait_nxt = '0;
    else if (r_wait_cnt < WW'(MAX_WAIT)) w_wait_nxt = r_wait_cnt + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= bus.mc_waddr;
      r_mem_data[r_wr_ptr] <= bus.mc_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_wait_cnt  <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_stall_req <= 1'b0;
      r_waw_err   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_wait_cnt  <= w_wait_nxt;
      r_stall_req <= (w_wait_nxt >= WW'(MAX_WAIT));
      r_waw_err   <= w_wb_req && w_hit_wb;
      case (w_gnt)
        GNT_WB: begin
          r_we    <= 1'b1;
          r_waddr <= bus.wb_waddr;
          r_wdata <= bus.wb_wdata;
        end
        GNT_MC: begin
          r_we    <= 1'b1;
          r_waddr <= r_mem_addr[r_rd_ptr];
          r_wdata <= r_mem_data[r_rd_ptr];
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  assign bus.mc_ready   = w_mc_ready;
  assign bus.rd_hazard1 = w_hit1 && (bus.raddr1 != '0);
  assign bus.rd_hazard2 = w_hit2 && (bus.raddr2 != '0);
  assign bus.stall_req  = r_stall_req;
  assign bus.waw_err    = r_waw_err;
  assign bus.we         = r_we;
  assign bus.waddr      = r_waddr;
  assign bus.wdata      = r_wdata;

`ifdef WB_ARB_STATS_EN
  logic [31:0] r_stat_stall_cyc;
  logic [31:0] r_stat_mc_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_stall_cyc <= '0;
      r_stat_mc_wr     <= '0;
    end else begin
      if (r_stall_req) r_stat_stall_cyc <= r_stat_stall_cyc + 32'd1;
      if (w_pop)       r_stat_mc_wr     <= r_stat_mc_wr + 32'd1;
    end
  end

  assign stat_stall_cyc = r_stat_stall_cyc;
  assign stat_mc_wr     = r_stat_mc_wr;
`endif

endmodule
